// File: rtl/range_pkg.sv
// Shared widths, powers-of-ten table and controller state encoding for range_sched.
package range_pkg;

  localparam int MAXDIG = 12;
  localparam int DW     = 40;
  localparam int AW     = 64;

  localparam logic [DW-1:0] POW10 [0:MAXDIG] = '{
    40'd1,
    40'd10,
    40'd100,
    40'd1000,
    40'd10000,
    40'd100000,
    40'd1000000,
    40'd10000000,
    40'd100000000,
    40'd1000000000,
    40'd10000000000,
    40'd100000000000,
    40'd1000000000000
  };

  typedef enum logic [2:0] {
    IDLE,
    SEG,
    DIVLO,
    DIVHI,
    MUL1,
    MUL2,
    NEXT
  } state_t;

endpackage

// File: rtl/range_sched_div40_seq.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses exactly DW cycles after start.
module div40_seq
  import range_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] src_rem, src_quo, src_dvs;
  logic [DW:0]   trial;
  logic [DW-1:0] rem_nx, quo_nx;

  // The first bit is resolved in the start cycle itself so the result lands DW cycles later.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    trial   = {src_rem, src_quo[DW-1]};
    if (trial >= {1'b0, src_dvs}) begin
      rem_nx = DW'(trial - {1'b0, src_dvs});
      quo_nx = {src_quo[DW-2:0], 1'b1};
    end else begin
      rem_nx = trial[DW-1:0];
      quo_nx = {src_quo[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        dvs_q <= divisor;
        cnt   <= CW'(DW - 1);
      end else if (cnt != '0) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt - 1'b1;
        done  <= (cnt == CW'(1));
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/range_sched.sv
// Splits ID ranges at decimal-length boundaries and sums doubled IDs of even-length segments.
// state | meaning: IDLE wait range, SEG size segment, DIVLO/DIVHI bound X, MUL1/MUL2 sum, NEXT advance
module range_sched
  import range_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_min,
  input  logic [DW-1:0] in_max,
  input  logic          in_last,
  output logic          busy,
  output logic [AW-1:0] result,
  output logic          result_valid,
  output logic          err
);

  state_t        state, state_nx;
  logic          entry;
  logic [DW-1:0] lo, hi, seg_hi, m, xa, xb;
  logic          last, err_sticky;
  logic [AW-1:0] p, acc;

  logic [3:0]    dig;
  logic [DW-1:0] seg_top, seg_hi_nx, m_nx;
  logic          illegal;
  logic          div_start, div_done;
  logic [DW-1:0] div_dividend, div_quotient;
  logic [AW-1:0] xa_w, xb_w;

  assign illegal = (in_min > in_max) || (in_max >= POW10[MAXDIG]);
  assign xa_w    = AW'(xa);
  assign xb_w    = AW'(xb);

  always_comb begin
    dig = 4'd1;
    for (int k = 1; k < MAXDIG; k++) begin
      if (lo >= POW10[k]) dig = 4'(k + 1);
    end
    seg_top   = POW10[dig] - DW'(1);
    seg_hi_nx = (hi < seg_top) ? hi : seg_top;
    m_nx      = POW10[dig >> 1] + DW'(1);
  end

  always_comb begin
    state_nx     = state;
    div_start    = 1'b0;
    div_dividend = seg_hi;
    case (state)
      IDLE:  if (in_valid) state_nx = illegal ? NEXT : SEG;
      SEG:   state_nx = dig[0] ? NEXT : DIVLO;
      DIVLO: begin
        div_start    = entry;
        div_dividend = lo + m - DW'(1);
        if (div_done) state_nx = DIVHI;
      end
      DIVHI: begin
        div_start = entry;
        if (div_done) state_nx = MUL1;
      end
      MUL1:  state_nx = MUL2;
      MUL2:  state_nx = NEXT;
      NEXT:  state_nx = (seg_hi < hi) ? SEG : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      entry        <= 1'b0;
      lo           <= '0;
      hi           <= '0;
      seg_hi       <= '0;
      m            <= '0;
      xa           <= '0;
      xb           <= '0;
      last         <= 1'b0;
      err_sticky   <= 1'b0;
      p            <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nx;
      entry        <= (state_nx != state);
      result_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          lo   <= in_min;
          hi   <= in_max;
          last <= in_last;
          // seg_hi == hi makes NEXT treat an illegal range as fully consumed
          if (illegal) begin
            seg_hi     <= in_max;
            err_sticky <= 1'b1;
          end
        end
        SEG: begin
          seg_hi <= seg_hi_nx;
          m      <= m_nx;
        end
        DIVLO: if (div_done) xa <= div_quotient;
        DIVHI: if (div_done) xb <= div_quotient;
        MUL1:  p   <= (xa > xb) ? '0 : ((xa_w + xb_w) * (xb_w - xa_w + AW'(1))) >> 1;
        MUL2:  acc <= acc + p * AW'(m);
        NEXT: begin
          if (seg_hi < hi) begin
            lo <= seg_hi + DW'(1);
          end else if (last) begin
            result       <= acc;
            result_valid <= 1'b1;
            err          <= err_sticky;
            acc          <= '0;
            err_sticky   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  div40_seq u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (m),
    .quotient (div_quotient),
    .done     (div_done)
  );

endmodule

// File: tb/tb_range_sched.sv
// Directed bench for range_sched: hand-computed totals, cycle counts and reset behaviour.
module tb_range_sched;
  import range_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_min = '0;
  logic [DW-1:0] in_max = '0;
  logic          in_last = 1'b0;
  logic          busy;
  logic [AW-1:0] result;
  logic          result_valid;
  logic          err;

  int n_assert = 0;
  int n_fail   = 0;
  int rv_cnt, busy_cnt, start_cnt;

  always #5 clk = ~clk;

  range_sched dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_min       (in_min),
    .in_max       (in_max),
    .in_last      (in_last),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .err          (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (result_valid) rv_cnt++;
    if (busy) busy_cnt++;
    if (dut.div_start) start_cnt++;
  endtask

  task automatic clear_counts();
    rv_cnt = 0;
    busy_cnt = 0;
    start_cnt = 0;
  endtask

  task automatic send(input logic [DW-1:0] mn, input logic [DW-1:0] mx, input logic lst);
    check("ready_before_send", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_min   = mn;
    in_max   = mx;
    in_last  = lst;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("wait_idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    clear_counts();
    // reset
    step();
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_rv", {63'd0, result_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    #1;
    step();
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // 11-22: 11 + 22
    clear_counts();
    send(40'd11, 40'd22, 1'b1);
    wait_idle(200);
    check("t1_rv", {63'd0, result_valid}, 64'd1);
    check("t1_result", result, 64'd33);
    check("t1_err", {63'd0, err}, 64'd0);
    check("t1_busy_cycles", 64'(busy_cnt), 64'd86);
    check("t1_div_starts", 64'(start_cnt), 64'd2);
    step();
    check("t1_rv_pulse", {63'd0, result_valid}, 64'd0);
    check("t1_result_held", result, 64'd33);
    check("t1_rv_count", 64'(rv_cnt), 64'd1);

    // 95-115: only 99, then odd 3-digit segment
    clear_counts();
    send(40'd95, 40'd115, 1'b1);
    wait_idle(300);
    check("t2_result", result, 64'd99);
    check("t2_busy_cycles", 64'(busy_cnt), 64'd88);

    // 1-9: single-digit, no divisions
    clear_counts();
    send(40'd1, 40'd9, 1'b1);
    wait_idle(50);
    check("t3_rv", {63'd0, result_valid}, 64'd1);
    check("t3_result", result, 64'd0);
    check("t3_busy_cycles", 64'(busy_cnt), 64'd2);
    check("t3_div_starts", 64'(start_cnt), 64'd0);

    // four-range stream, one result
    clear_counts();
    send(40'd11, 40'd22, 1'b0);
    wait_idle(200);
    send(40'd95, 40'd115, 1'b0);
    wait_idle(300);
    send(40'd998, 40'd1012, 1'b0);
    wait_idle(300);
    check("t4_no_early_rv", 64'(rv_cnt), 64'd0);
    send(40'd1188511880, 40'd1188511890, 1'b1);
    wait_idle(200);
    check("t4_result", result, 64'd1188513027);
    check("t4_rv_count", 64'(rv_cnt), 64'd1);

    // illegal min>max then legal last
    clear_counts();
    send(40'd50, 40'd40, 1'b0);
    wait_idle(20);
    check("t5_illegal_busy", 64'(busy_cnt), 64'd1);
    send(40'd10, 40'd12, 1'b1);
    wait_idle(200);
    check("t5_result", result, 64'd11);
    check("t5_err", {63'd0, err}, 64'd1);
    send(40'd11, 40'd11, 1'b1);
    wait_idle(200);
    check("t5b_result", result, 64'd11);
    check("t5b_err_cleared", {63'd0, err}, 64'd0);

    // max at 10^MAXDIG is illegal
    send(40'd5, 40'd1000000000000, 1'b1);
    wait_idle(20);
    check("t6_rv", {63'd0, result_valid}, 64'd1);
    check("t6_result", result, 64'd0);
    check("t6_err", {63'd0, err}, 64'd1);

    // reset during DIVHI of 998-1012
    clear_counts();
    send(40'd998, 40'd1012, 1'b0);
    for (int i = 0; i < 48; i++) step();
    check("t7_in_divhi", 64'(dut.state), 64'(DIVHI));
    rst = 1'b1;
    #1;
    check("t7_ready_in_reset", {63'd0, in_ready}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("t7_busy_after_reset", {63'd0, busy}, 64'd0);
    check("t7_ready_after_reset", {63'd0, in_ready}, 64'd1);
    check("t7_result_cleared", result, 64'd0);
    check("t7_no_rv_abort", 64'(rv_cnt), 64'd0);
    step();
    send(40'd11, 40'd22, 1'b1);
    wait_idle(200);
    check("t7_result", result, 64'd33);
    check("t7_err", {63'd0, err}, 64'd0);
    check("t7_rv_count", 64'(rv_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
